i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

I2C target (slave) engine answering the bus driven by the team's I2C master controller. Oversamples SCL/SDA with `i2c_clk`, detects START/STOP, matches a fixed 7-bit address, and either receives bytes into an RX FIFO or transmits bytes popped from a TX FIFO. SDA is driven open-drain: the block only ever pulls low or releases. No clock stretching and no general call.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit target address.
- `i2c_clk`  in  1  oversampling clock; must be at least 8x the SCL frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scl_in`  in  1  raw SCL pin level, asynchronous.
- `sda_in`  in  1  raw SDA pin level, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (pull-up).
- `rx_data`  out  8  last received data byte.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` holds a new byte (RX FIFO push).
- `rx_ready`  in  1  RX FIFO has space; 0 causes NACK.
- `tx_data`  in  8  TX FIFO head byte.
- `tx_valid`  in  1  TX FIFO non-empty.
- `tx_req`  out  1  one-cycle pulse: `tx_data` consumed (TX FIFO pop).
- `busy`  out  1  1 from START to STOP.
- `selected`  out  1  1 after address match until STOP or repeated START.

## Operation
- Input path: 2-flop synchronizer on `scl_in` and `sda_in`, plus a registered copy for edge detection. All decisions use the synchronized values `scl_s` and `sda_s`.
- START: `sda_s` falls while `scl_s`=1. STOP: `sda_s` rises while `scl_s`=1.
- START/STOP detection has priority over every state, including a repeated START mid-byte.
  - START → ADDR: bit counter = 7, `sda_oe` = 0, `busy` = 1, `selected` = 0.
  - STOP → IDLE: `sda_oe` = 0, `busy` = 0, `selected` = 0.
- Data bits are sampled on the rising edge of `scl_s`, MSB first, into an 8-bit shift register; the 3-bit counter decrements each sample. SDA drive changes only on the falling edge of `scl_s`.
- States:
  - IDLE: wait for START.
  - ADDR: 8 bits sampled. On the 8th SCL fall:
    - if shift[7:1] == `SLAVE_ADDR`: latch rw = shift[0], `selected` = 1, `sda_oe` = 1, go ADDR_ACK;
    - otherwise go WAIT_STOP.
  - ADDR_ACK: on the 9th SCL fall:
    - rw = 0: `sda_oe` = 0, go RX_DATA;
    - rw = 1: load the TX byte, `sda_oe` = ~byte[7], go TX_DATA.
  - RX_DATA: 8 bits sampled. On the 8th fall:
    - `rx_ready` = 1: `rx_data` = shift, `rx_valid` pulse, `sda_oe` = 1, go RX_ACK;
    - `rx_ready` = 0: byte dropped, `sda_oe` = 0 (NACK), go WAIT_STOP.
  - RX_ACK: on the 9th fall: `sda_oe` = 0, counter = 7, go RX_DATA.
  - TX_DATA: on each fall after bit n, `sda_oe` = ~byte[n-1]. On the 8th fall: `sda_oe` = 0, go TX_ACK.
  - TX_ACK: sample `sda_s` on the 9th rise. On the 9th fall:
    - master ACK (0): load the next TX byte and drive bit 7, go TX_DATA;
    - master NACK (1): `sda_oe` = 0, go WAIT_STOP.
  - WAIT_STOP: `sda_oe` = 0; ignore SCL; leave only on STOP or START.
- TX byte load: if `tx_valid` = 1, take `tx_data` and pulse `tx_req`. If `tx_valid` = 0, send 8'hFF (bus stays released) with no `tx_req`.
- `rx_valid` and `tx_req` never assert in the same cycle. Each is exactly 1 cycle wide.

## Timing
- Reset values: `sda_oe` 0, `rx_data` 8'h00, `rx_valid` 0, `tx_req` 0, `busy` 0, `selected` 0, state IDLE. Synchronizer flops reset to 1 (idle bus).
- Reset mid-transfer: `sda_oe` drops to 0 asynchronously. After release, the block re-arms in IDLE and ignores the bus until the next START.
- Latency: pin change → detected edge = 3 `i2c_clk` cycles. Detected SCL fall → `sda_oe` update on the next edge (4 cycles after the pin). This fits in the SCL low phase because of the ≥8x requirement.
- `rx_valid` and `tx_req` pulse in the same cycle as the corresponding SCL-fall state update.
- SDA sampling uses the `sda_s` value present in the cycle where the `scl_s` rise is detected. Both inputs share a synchronizer depth, so skew is preserved.
- No glitch filter. A STOP or START in the middle of a byte aborts it; a partial byte is never pushed.

## Test plan
- Write: START, 0xA0, 0x3C, STOP (`SLAVE_ADDR` 0x50) → `sda_oe`=1 during ACK clocks 9 and 18; `rx_data`=0x3C with one `rx_valid` pulse; `busy`=0 after STOP.
- Address mismatch: START, 0xA2, 0x55, STOP → `sda_oe` stays 0 throughout; no `rx_valid`; `selected` stays 0.
- Read: START, 0xA1; `tx_data` 0x96 then 0x5A; master ACKs the first byte and NACKs the second → SDA shows 10010110 then 01011010; two `tx_req` pulses; SDA released after the NACK.
- Write with `rx_ready`=0: START, 0xA0, 0x77 → NACK on clock 18; no `rx_valid`; further bytes ignored until STOP.
- Repeated start: START, 0xA0, 0x11, Sr, 0xA1 → `rx_data`=0x11; then TX mode with one `tx_req` at the ACK fall; `busy` stays 1 across Sr.
- Reset during the address ACK (`sda_oe`=1) → `sda_oe`=0 immediately; the block stays IDLE until a new START, then completes the write of 0xA0, 0x42 normally.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target engine: oversampled START/STOP detection, 7-bit address match,
// byte receive into an RX FIFO and byte transmit from a TX FIFO, open-drain SDA.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       i2c_clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       selected
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_WAIT_STOP
  } state_e;

  logic       scl_meta_q, scl_s_q, scl_prev_q;
  logic       sda_meta_q, sda_s_q, sda_prev_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] tx_byte;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       selected_q, selected_d;

  // Idle bus is high on both lines, so the synchronizers reset to 1.
  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_in;
      scl_s_q    <= scl_meta_q;
      scl_prev_q <= scl_s_q;
      sda_meta_q <= sda_in;
      sda_s_q    <= sda_meta_q;
      sda_prev_q <= sda_s_q;
    end
  end

  assign scl_rise  = scl_s_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q & scl_prev_q;
  assign start_det = scl_s_q & sda_prev_q & ~sda_s_q;
  assign stop_det  = scl_s_q & ~sda_prev_q & sda_s_q;
  assign tx_byte   = tx_valid ? tx_data : 8'hFF;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    selected_d = selected_q;

    if (start_det) begin
      state_d    = ST_ADDR;
      cnt_d      = 3'd7;
      done_d     = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
      selected_d = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      selected_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_RX_DATA: begin
          // done_q marks that all 8 bits are in; the byte is acted on at the next fall.
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s_q};
            cnt_d   = cnt_q - 3'd1;
            if (cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                rw_d       = shift_q[0];
                selected_d = 1'b1;
                sda_oe_d   = 1'b1;
                state_d    = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_RX_ACK;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d  = 3'd7;
            done_d = 1'b0;
            if (!rw_q) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX_DATA;
            end else begin
              shift_d  = tx_byte;
              tx_req_d = tx_valid;
              sda_oe_d = ~tx_byte[7];
              state_d  = ST_TX_DATA;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 3'd7;
            done_d   = 1'b0;
            state_d  = ST_RX_DATA;
          end
        end
        ST_TX_DATA: begin
          // cnt_q already points at the next bit to present after each rise.
          if (scl_rise) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd0) done_d = 1'b1;
          end else if (scl_fall) begin
            if (done_q) begin
              done_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[cnt_q];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            ack_d = sda_s_q;
          end else if (scl_fall) begin
            if (!ack_q) begin
              shift_d  = tx_byte;
              tx_req_d = tx_valid;
              sda_oe_d = ~tx_byte[7];
              cnt_d    = 3'd7;
              done_d   = 1'b0;
              state_d  = ST_TX_DATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd7;
      done_q     <= 1'b0;
      shift_q    <= 8'h00;
      rw_q       <= 1'b0;
      ack_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      selected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      selected_q <= selected_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign selected = selected_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bus-master model drives SCL/SDA, a transaction-level
// model predicts ACKs, read bytes and FIFO traffic, and a monitor scores the FIFO pulses.
module tb_i2c_slave_responder;

  localparam int         Q    = 50;
  localparam logic [6:0] ADDR = 7'h50;

  logic       i2c_clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m, sda_line;
  logic       sda_oe, rx_valid, rx_ready, tx_req, busy, selected;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic [7:0] rx_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] tx_fifo[$];
  logic [7:0] data_a[8];
  bit         rdy_a[8];

  always #5 i2c_clk = ~i2c_clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_responder #(.SLAVE_ADDR(ADDR)) dut (
    .i2c_clk  (i2c_clk),
    .rst_n    (rst_n),
    .scl_in   (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_req   (tx_req),
    .busy     (busy),
    .selected (selected)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO pulse must match the head of the model's expectation queues.
  always @(negedge i2c_clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid || tx_req) chk("pulse_exclusive", 32'(rx_valid & tx_req), 32'(0));
      if (rx_valid) begin
        chk("rx_push_expected", 32'(rx_q.size() > 0), 32'(1));
        if (rx_q.size() > 0) chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
      end
      if (tx_req) begin
        chk("tx_pop_expected", 32'(exp_tx_q.size() > 0), 32'(1));
        if (exp_tx_q.size() > 0) chk("tx_pop_byte", 32'(tx_data), 32'(exp_tx_q.pop_front()));
        if (tx_fifo.size() > 0) void'(tx_fifo.pop_front());
      end
    end
    tx_valid = (tx_fifo.size() > 0);
    tx_data  = (tx_fifo.size() > 0) ? tx_fifo[0] : 8'h00;
  end

  task automatic bit_clk(input logic o, output logic i);
    sda_m = o;    #Q;
    scl_m = 1'b1; #Q;
    i = sda_line; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int k = 7; k >= 0; k--) bit_clk(b[k], d);
    bit_clk(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int k = 7; k >= 0; k--) begin
      bit_clk(1'b1, d);
      b[k] = d;
    end
    bit_clk(mack, d);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("selected_after_start", 32'(selected), 32'(0));
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    chk("busy_after_stop", 32'(busy), 32'(0));
    chk("selected_after_stop", 32'(selected), 32'(0));
  endtask

  // Write: the target ACKs its address, then each byte while it has room; the first
  // refused byte is NACKed and everything after it is ignored.
  task automatic run_write(input logic [7:0] addr, input int n, input bit do_stop);
    logic ack, eack;
    bit   alive;
    alive = (addr[7:1] == ADDR);
    bus_start();
    write_byte(addr, ack);
    chk("addr_ack_w", 32'(ack), 32'(alive ? 1'b0 : 1'b1));
    chk("selected_w", 32'(selected), 32'(alive));
    for (int i = 0; i < n; i++) begin
      rx_ready = rdy_a[i];
      if (alive && rdy_a[i]) begin
        rx_q.push_back(data_a[i]);
        eack = 1'b0;
      end else begin
        eack  = 1'b1;
        alive = 1'b0;
      end
      write_byte(data_a[i], ack);
      chk("data_ack", 32'(ack), 32'(eack));
    end
    rx_ready = 1'b1;
    if (do_stop) bus_stop();
  endtask

  // Read: bytes come from the TX FIFO in order, 8'hFF once it runs dry; master ACKs all
  // but the last byte.
  task automatic run_read(input logic [6:0] a7, input int n, input bit do_stop);
    logic       ack;
    logic [7:0] b, eb;
    logic [7:0] mq[$];
    bit         match;
    match = (a7 == ADDR);
    mq = tx_fifo;
    if (match)
      for (int i = 0; i < n; i++)
        if (i < mq.size()) exp_tx_q.push_back(mq[i]);
    bus_start();
    write_byte({a7, 1'b1}, ack);
    chk("addr_ack_r", 32'(ack), 32'(match ? 1'b0 : 1'b1));
    chk("selected_r", 32'(selected), 32'(match));
    if (!match) begin
      bus_stop();
    end else begin
      for (int i = 0; i < n; i++) begin
        eb = (i < mq.size()) ? mq[i] : 8'hFF;
        read_byte((i == n - 1) ? 1'b1 : 1'b0, b);
        chk("read_byte", 32'(b), 32'(eb));
      end
      chk("sda_released", 32'(sda_oe), 32'(0));
      if (do_stop) bus_stop();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: stimulus did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack;
    logic [7:0] ab;
    logic [6:0] a7;
    bit         rd, stp, match;
    int         n, k;

    rst_n    = 1'b0;
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge i2c_clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_tx_req", 32'(tx_req), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_selected", 32'(selected), 32'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge i2c_clk);

    // Basic write.
    data_a[0] = 8'h3C; rdy_a[0] = 1'b1;
    run_write(8'hA0, 1, 1'b1);
    // Address mismatch.
    data_a[0] = 8'h55; rdy_a[0] = 1'b1;
    run_write(8'hA2, 1, 1'b1);
    // Two-byte read, second byte NACKed by the master.
    tx_fifo.push_back(8'h96);
    tx_fifo.push_back(8'h5A);
    repeat (2) @(negedge i2c_clk);
    run_read(ADDR, 2, 1'b1);
    // RX FIFO full: NACK, later bytes ignored.
    data_a[0] = 8'h77; rdy_a[0] = 1'b0;
    data_a[1] = 8'h12; rdy_a[1] = 1'b1;
    run_write(8'hA0, 2, 1'b1);
    // Repeated START from write into read.
    data_a[0] = 8'h11; rdy_a[0] = 1'b1;
    run_write(8'hA0, 1, 1'b0);
    tx_fifo.push_back(8'hC3);
    repeat (2) @(negedge i2c_clk);
    run_read(ADDR, 1, 1'b1);
    chk("rx_data_hold", 32'(rx_data), 32'(8'h11));

    // Reset while the target is driving the address ACK.
    bus_start();
    ab = 8'hA0;
    for (int b = 7; b >= 0; b--) bit_clk(ab[b], ack);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    chk("ack_oe_before_reset", 32'(sda_oe), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("sda_oe_async_reset", 32'(sda_oe), 32'(0));
    repeat (2) @(negedge i2c_clk);
    rst_n = 1'b1;
    chk("busy_after_reset", 32'(busy), 32'(0));
    chk("rx_data_after_reset", 32'(rx_data), 32'(0));
    scl_m = 1'b0; #Q;
    write_byte(ab, ack);
    chk("ignored_without_start", 32'(ack), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));
    data_a[0] = 8'h42; rdy_a[0] = 1'b1;
    run_write(8'hA0, 1, 1'b1);

    // Randomized transactions, mixing matches, reads, writes, stalls and repeated STARTs.
    for (int t = 0; t < 14; t++) begin
      match = ($urandom_range(0, 3) != 0);
      a7    = match ? ADDR : 7'($urandom);
      if (!match && a7 == ADDR) a7 = a7 ^ 7'h01;
      rd  = 1'($urandom_range(0, 1));
      stp = (t == 13) || ($urandom_range(0, 3) != 0);
      n   = $urandom_range(1, 3);
      if (rd) begin
        k = $urandom_range(0, n);
        for (int i = 0; i < k; i++) tx_fifo.push_back(8'($urandom));
        repeat (2) @(negedge i2c_clk);
        run_read(a7, n, stp);
      end else begin
        for (int i = 0; i < n; i++) begin
          data_a[i] = 8'($urandom);
          rdy_a[i]  = ($urandom_range(0, 3) != 0);
        end
        run_write({a7, 1'b0}, n, stp);
      end
    end

    repeat (10) @(negedge i2c_clk);
    chk("rx_expect_drained", 32'(rx_q.size()), 32'(0));
    chk("tx_expect_drained", 32'(exp_tx_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
